vxe_cu_cmd_mem_resp: RTL and testbench

// Memory-side responder for the CU fetch request protocol. Pops 44-bit read requests from the

---
 rtl/vxe_cu_cmd_mem_resp.sv | 140 ++++++++++++++
 tb/tb_vxe_cu_cmd_mem_resp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vxe_cu_cmd_mem_resp.sv
// -----------------------------------------------------------------------------
// vxe_cu_cmd_mem_resp
// Memory-side responder for the CU fetch request protocol. Read requests are
// popped from the request FIFO, looked up in a local 64-bit command SRAM and
// answered with one status word (rss FIFO) plus one data word (rsd FIFO).
// Responses leave in request order. The block serves as an on-chip command
// store and as a bench model.
//
// Ports
//   clk, nrst              clock, asynchronous active-low reset
//   i_rqa_vld / i_rqa      request FIFO non-empty / head request
//                          [43:42] client id, [41:37] txn id, [36:0] word addr
//   o_rqa_rd               pop request FIFO (combinational)
//   i_rss_rdy / o_rss /    status FIFO handshake; status is
//   o_rss_wr               [8:7] client id, [6:2] txn id, [1:0] code
//                          (00 OK, 01 address error)
//   i_rsd_rdy / o_rsd /    data FIFO handshake; data is 0 on error
//   o_rsd_wr
//   i_ld_we / i_ld_addr /  SRAM load port
//   i_ld_data
//   o_busy                 request in flight or response buffered
// -----------------------------------------------------------------------------
module vxe_cu_cmd_mem_resp #(
  parameter int          DEPTH_POW2 = 8,
  parameter logic [36:0] BASE_ADDR  = 37'h0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_rqa_vld,
  input  logic [43:0]           i_rqa,
  output logic                  o_rqa_rd,
  input  logic                  i_rss_rdy,
  output logic [8:0]            o_rss,
  output logic                  o_rss_wr,
  input  logic                  i_rsd_rdy,
  output logic [63:0]           o_rsd,
  output logic                  o_rsd_wr,
  input  logic                  i_ld_we,
  input  logic [DEPTH_POW2-1:0] i_ld_addr,
  input  logic [63:0]           i_ld_data,
  output logic                  o_busy
);

  localparam int DEPTH = 1 << DEPTH_POW2;

  logic [63:0] mem [DEPTH];
  logic [63:0] rd_data;

  logic [36:0]           req_addr;
  logic [36:0]           req_off;
  logic                  req_err;
  logic [DEPTH_POW2-1:0] req_idx;

  logic       s1_vld;
  logic [1:0] s1_cl;
  logic [4:0] s1_txn;
  logic       s1_err;

  logic [8:0]  ent_rss [2];
  logic [63:0] ent_rsd [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  buf_cnt;

  logic [1:0] cnt;
  logic       drain;

  // The offset is only meaningful when addr >= BASE_ADDR; any set bit above
  // the index field means the request lies past the end of the SRAM.
  assign req_addr = i_rqa[36:0];
  assign req_off  = req_addr - BASE_ADDR;
  assign req_err  = (req_addr < BASE_ADDR) || (req_off[36:DEPTH_POW2] != '0);
  assign req_idx  = req_off[DEPTH_POW2-1:0];

  // Credits cover the entry in the SRAM read stage plus buffered entries, so
  // the 2-entry buffer can never overflow. A drain in the same cycle frees a
  // slot, which keeps one response per cycle flowing when the buffer is full.
  assign cnt      = {1'b0, s1_vld} + buf_cnt;
  assign o_rss_wr = (buf_cnt != 2'd0);
  assign o_rsd_wr = o_rss_wr;
  assign drain    = o_rss_wr && i_rss_rdy && i_rsd_rdy;
  assign o_rqa_rd = i_rqa_vld && ((cnt < 2'd2) || drain);
  assign o_busy   = (cnt != 2'd0);

  assign o_rss = ent_rss[rd_ptr];
  assign o_rsd = ent_rsd[rd_ptr];

  // SRAM: loads land at the edge, so a read of the same index in the same
  // cycle still sees the old word. Out-of-range requests skip the read.
  always_ff @(posedge clk) begin
    if (i_ld_we) begin
      mem[i_ld_addr] <= i_ld_data;
    end
    if (o_rqa_rd && !req_err) begin
      rd_data <= mem[req_idx];
    end
  end

  // Request fields travel alongside the synchronous SRAM read.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_vld <= 1'b0;
      s1_cl  <= 2'd0;
      s1_txn <= 5'd0;
      s1_err <= 1'b0;
    end else begin
      s1_vld <= o_rqa_rd;
      if (o_rqa_rd) begin
        s1_cl  <= i_rqa[43:42];
        s1_txn <= i_rqa[41:37];
        s1_err <= req_err;
      end
    end
  end

  // Output buffer as a 2-entry ring. When s1_vld is set the credit limit
  // guarantees the slot at wr_ptr is free, even if the head drains now.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 2; i++) begin
        ent_rss[i] <= 9'd0;
        ent_rsd[i] <= 64'd0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (s1_vld) begin
        ent_rss[wr_ptr] <= {s1_cl, s1_txn, s1_err ? 2'b01 : 2'b00};
        ent_rsd[wr_ptr] <= s1_err ? 64'd0 : rd_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (drain) begin
        rd_ptr <= ~rd_ptr;
      end
      buf_cnt <= buf_cnt + {1'b0, s1_vld} - {1'b0, drain};
    end
  end

endmodule

// File: tb/tb_vxe_cu_cmd_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_vxe_cu_cmd_mem_resp
// Directed bench for vxe_cu_cmd_mem_resp. A request FIFO model feeds the DUT,
// expected responses are queued when requests are issued and compared against
// the buffer head whenever the DUT presents a response.
// -----------------------------------------------------------------------------
module tb_vxe_cu_cmd_mem_resp;

  logic        clk;
  logic        nrst;
  logic        i_rqa_vld;
  logic [43:0] i_rqa;
  logic        o_rqa_rd;
  logic        i_rss_rdy;
  logic [8:0]  o_rss;
  logic        o_rss_wr;
  logic        i_rsd_rdy;
  logic [63:0] o_rsd;
  logic        o_rsd_wr;
  logic        i_ld_we;
  logic [7:0]  i_ld_addr;
  logic [63:0] i_ld_data;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  int cyc     = 0;
  logic chk_lat = 1'b0;

  logic [43:0] req_q [$];
  logic [72:0] exp_q [$];
  int          pop_cyc_q [$];
  logic [63:0] tb_mem [256];

  vxe_cu_cmd_mem_resp #(.DEPTH_POW2(8), .BASE_ADDR(37'h0)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_rqa_vld (i_rqa_vld),
    .i_rqa     (i_rqa),
    .o_rqa_rd  (o_rqa_rd),
    .i_rss_rdy (i_rss_rdy),
    .o_rss     (o_rss),
    .o_rss_wr  (o_rss_wr),
    .i_rsd_rdy (i_rsd_rdy),
    .o_rsd     (o_rsd),
    .o_rsd_wr  (o_rsd_wr),
    .i_ld_we   (i_ld_we),
    .i_ld_addr (i_ld_addr),
    .i_ld_data (i_ld_data),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue one request and its model response.
  task automatic applyStimulus(input logic [1:0] cl, input logic [4:0] txn, input logic [36:0] addr);
    logic [8:0]  rss;
    logic [63:0] rsd;
    if (addr < 37'd256) begin
      rss = {cl, txn, 2'b00};
      rsd = tb_mem[addr[7:0]];
    end else begin
      rss = {cl, txn, 2'b01};
      rsd = 64'd0;
    end
    req_q.push_back({cl, txn, addr});
    exp_q.push_back({rss, rsd});
  endtask

  task automatic loadWord(input logic [7:0] idx, input logic [63:0] data);
    @(posedge clk); #1;
    i_ld_we   = 1'b1;
    i_ld_addr = idx;
    i_ld_data = data;
    tb_mem[idx] = data;
    @(posedge clk); #1;
    i_ld_we = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitPush(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_rss_wr) break;
    end
    checkOutput(tag, {63'd0, o_rss_wr}, 64'd1);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_busy) break;
    end
    checkOutput({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    checkOutput({tag, "_sb"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Request FIFO model: a pop is decided on what is visible mid-cycle and
  // takes effect after the following edge.
  initial begin
    logic pop;
    i_rqa_vld = 1'b0;
    i_rqa     = 44'd0;
    forever begin
      @(negedge clk);
      pop = nrst && i_rqa_vld && o_rqa_rd;
      if (pop) pop_cyc_q.push_back(cyc);
      @(posedge clk); #1;
      if (pop && req_q.size() != 0) void'(req_q.pop_front());
      i_rqa_vld = (req_q.size() != 0);
      i_rqa     = (req_q.size() != 0) ? req_q[0] : 44'd0;
    end
  end

  // Response monitor: the buffer head must always match the oldest
  // outstanding expectation; it is retired only on a full handshake.
  initial begin
    logic [72:0] e;
    int          pc;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (o_rss_wr) begin
          checkOutput("rsd_wr_hi", {63'd0, o_rsd_wr}, 64'd1);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_push", {63'd0, o_rss_wr}, 64'd0);
          end else begin
            e = exp_q[0];
            checkOutput("rss", {55'd0, o_rss}, {55'd0, e[72:64]});
            checkOutput("rsd", o_rsd, e[63:0]);
            if (i_rss_rdy && i_rsd_rdy) begin
              void'(exp_q.pop_front());
              pc = (pop_cyc_q.size() != 0) ? pop_cyc_q.pop_front() : -100;
              n_deliv++;
              if (chk_lat) checkOutput("latency", 64'(cyc - pc), 64'd2);
            end
          end
        end else begin
          checkOutput("rsd_wr_lo", {63'd0, o_rsd_wr}, 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    nrst      = 1'b0;
    i_rss_rdy = 1'b1;
    i_rsd_rdy = 1'b1;
    i_ld_we   = 1'b0;
    i_ld_addr = 8'd0;
    i_ld_data = 64'd0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 64'd0;

    // Reset values.
    waitCycles(3);
    @(negedge clk);
    checkOutput("rst_rss_wr", {63'd0, o_rss_wr}, 64'd0);
    checkOutput("rst_rsd_wr", {63'd0, o_rsd_wr}, 64'd0);
    checkOutput("rst_rss", {55'd0, o_rss}, 64'd0);
    checkOutput("rst_rsd", o_rsd, 64'd0);
    checkOutput("rst_busy", {63'd0, o_busy}, 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Single good read, exact 2-cycle latency.
    loadWord(8'd5, 64'hA5A5_0000_1111_2222);
    chk_lat = 1'b1;
    applyStimulus(2'd0, 5'd3, 37'd5);
    waitPush("t1_push");
    checkOutput("t1_rss", {55'd0, o_rss}, 64'h00C);
    checkOutput("t1_rsd", o_rsd, 64'hA5A5_0000_1111_2222);
    waitIdle("t1");

    // Address just past the SRAM.
    applyStimulus(2'd2, 5'd1, 37'h100);
    waitPush("t2_push");
    checkOutput("t2_rss", {55'd0, o_rss}, 64'h105);
    checkOutput("t2_rsd", o_rsd, 64'd0);
    waitIdle("t2");

    // Last valid index and the largest address.
    loadWord(8'd255, 64'hFEED_FACE_0BAD_F00D);
    applyStimulus(2'd3, 5'd31, 37'hFF);
    applyStimulus(2'd1, 5'd17, 37'h1F_FFFF_FFFF);
    waitIdle("t_bound");

    // Back-to-back burst, all ready.
    for (int i = 0; i < 8; i++) loadWord(8'(i), 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h1111_1111));
    d0 = n_deliv;
    for (int i = 0; i < 8; i++) applyStimulus(2'(i), 5'(i + 8), 37'(i));
    waitIdle("t3");
    checkOutput("t3_count", 64'(n_deliv - d0), 64'd8);

    // Burst with the data FIFO stalled mid-way.
    chk_lat = 1'b0;
    d0 = n_deliv;
    for (int i = 0; i < 8; i++) applyStimulus(2'(7 - i), 5'(i), 37'(7 - i));
    waitCycles(3);
    i_rsd_rdy = 1'b0;
    waitCycles(3);
    @(negedge clk);
    checkOutput("t4_rqa_rd", {63'd0, o_rqa_rd}, 64'd0);
    checkOutput("t4_pending", {63'd0, req_q.size() != 0}, 64'd1);
    checkOutput("t4_busy", {63'd0, o_busy}, 64'd1);
    waitCycles(2);
    i_rsd_rdy = 1'b1;
    waitIdle("t4");
    checkOutput("t4_count", 64'(n_deliv - d0), 64'd8);

    // Status side ready, data side not: nothing may be consumed.
    d0 = n_deliv;
    i_rsd_rdy = 1'b0;
    applyStimulus(2'd1, 5'd9, 37'd2);
    waitCycles(5);
    @(negedge clk);
    checkOutput("t5_wr", {63'd0, o_rss_wr}, 64'd1);
    checkOutput("t5_none", 64'(n_deliv - d0), 64'd0);
    @(posedge clk); #1;
    i_rsd_rdy = 1'b1;
    waitIdle("t5");
    checkOutput("t5_single", 64'(n_deliv - d0), 64'd1);

    // Reset with two buffered responses, then normal service.
    i_rss_rdy = 1'b0;
    i_rsd_rdy = 1'b0;
    applyStimulus(2'd0, 5'd4, 37'd1);
    applyStimulus(2'd0, 5'd5, 37'd3);
    waitCycles(6);
    @(negedge clk);
    checkOutput("t6_pre_busy", {63'd0, o_busy}, 64'd1);
    checkOutput("t6_pre_wr", {63'd0, o_rss_wr}, 64'd1);
    @(posedge clk); #2;
    nrst = 1'b0;
    #1;
    checkOutput("t6_rst_wr", {63'd0, o_rss_wr}, 64'd0);
    checkOutput("t6_rst_rsd_wr", {63'd0, o_rsd_wr}, 64'd0);
    checkOutput("t6_rst_busy", {63'd0, o_busy}, 64'd0);
    exp_q.delete();
    pop_cyc_q.delete();
    req_q.delete();
    waitCycles(2);
    nrst      = 1'b1;
    i_rss_rdy = 1'b1;
    i_rsd_rdy = 1'b1;
    chk_lat   = 1'b1;
    d0 = n_deliv;
    applyStimulus(2'd3, 5'd22, 37'd5);
    waitIdle("t6");
    checkOutput("t6_count", 64'(n_deliv - d0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
